spi_host_seq: RTL and testbench

SPI_HOST_SEQ -- requirements
Module: spi_host_seq

---
 rtl/spi_sram_pkg.sv | 27 ++
 rtl/spi_host_shreg.sv | 33 +++
 rtl/spi_host_seq.sv | 137 +++++++++++++
 tb/tb_spi_host_seq.sv | 137 +++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI SRAM host sequencer.
package spi_sram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_TURN,
      ST_RDATA,
      ST_DONE
   } state_t;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_TURN_CYC = 1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_host_shreg.sv
// Shift register: parallel-load/serial-out and serial-in/parallel-out, selectable direction.
module spi_host_shreg #(
   parameter int W  = 16,
   parameter int PW = 8
) (
   input  logic          sck,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   input  logic          shift,
   input  logic          ser_in,
   input  logic          lsb_first,
   output logic          ser_out,
   output logic [PW-1:0] par_out
);

   logic [W-1:0] q;

   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= lsb_first ? {ser_in, q[W-1:1]} : {q[W-2:0], ser_in};
      end
   end

   // Serial-in words accumulate at the end opposite to the shift-out end.
   assign ser_out = lsb_first ? q[0] : q[W-1];
   assign par_out = lsb_first ? q[W-1 -: PW] : q[PW-1:0];

endmodule

// File: rtl/spi_host_seq.sv
// SPI host sequencer for a serial SRAM: command bit, address, then write data or turnaround + read data.
// Build option: SPI_HOST_LSB_FIRST_EN shifts address/write/read fields LSB first (default MSB first).
//
// state | meaning
// IDLE  | waiting for start
// CMD   | command bit on sdi (1 = write, 0 = read)
// ADDR  | address bits on sdi, lA high
// WDATA | write data bits on sdi, dA high
// TURN  | read turnaround, sdo ignored
// RDATA | read bits sampled from sdo
// DONE  | ss low, done pulse, read word published
module spi_host_seq
   import spi_sram_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int TURN_CYC = DEF_TURN_CYC
) (
   input  logic              sck,
   input  logic              rst,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              abort,
   input  logic              sdo,
   output logic              sdi,
   output logic              ss,
   output logic              lA,
   output logic              dA,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata
);

   localparam int SH_W  = ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(max3(ADDR_W, DATA_W, TURN_CYC) + 1);

`ifdef SPI_HOST_LSB_FIRST_EN
   localparam logic LSB_FIRST = 1'b1;
`else
   localparam logic LSB_FIRST = 1'b0;
`endif

   state_t            state, nxt;
   logic [CNT_W-1:0]  cnt, cnt_reload;
   logic              last;
   logic              rw_q;
   logic              sh_load, sh_shift, sh_out;
   logic [SH_W-1:0]   sh_val;
   logic [DATA_W-1:0] rd_word;
   logic              sdi_d;

   assign last    = (cnt == '0);
   assign sh_load = (state == ST_IDLE) && start && !abort;
   // Field order in the register matches the order bits leave it.
   assign sh_val  = LSB_FIRST ? {wdata, addr} : {addr, wdata};

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  if (start && !abort) nxt = ST_CMD;
         ST_CMD:   nxt = ST_ADDR;
         ST_ADDR:  if (last) nxt = (rw_q == CMD_WRITE) ? ST_WDATA : ST_TURN;
         ST_WDATA: if (last) nxt = ST_DONE;
         ST_TURN:  if (last) nxt = ST_RDATA;
         ST_RDATA: if (last) nxt = ST_DONE;
         ST_DONE:  nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
      if (abort && state != ST_IDLE) nxt = ST_IDLE;
   end

   always_comb begin
      cnt_reload = '0;
      case (nxt)
         ST_ADDR:           cnt_reload = CNT_W'(ADDR_W - 1);
         ST_WDATA, ST_RDATA: cnt_reload = CNT_W'(DATA_W - 1);
         ST_TURN:           cnt_reload = CNT_W'(TURN_CYC - 1);
         default:           cnt_reload = '0;
      endcase
   end

   // Outputs are registered from the next state, so the bit on sdi is shifted out on entry.
   always_comb begin
      sh_shift = (nxt == ST_ADDR) || (nxt == ST_WDATA) || (state == ST_RDATA);
      sdi_d    = 1'b0;
      case (nxt)
         ST_CMD:            sdi_d = rw;
         ST_ADDR, ST_WDATA: sdi_d = sh_out;
         default:           sdi_d = 1'b0;
      endcase
   end

   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         rw_q  <= CMD_READ;
         sdi   <= 1'b0;
         ss    <= 1'b0;
         lA    <= 1'b0;
         dA    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         rdata <= '0;
      end else begin
         state <= nxt;
         if (nxt != state)  cnt <= cnt_reload;
         else if (!last)    cnt <= cnt - CNT_W'(1);
         if (sh_load)       rw_q <= rw;
         sdi  <= sdi_d;
         ss   <= (nxt != ST_IDLE) && (nxt != ST_DONE);
         lA   <= (nxt == ST_ADDR);
         dA   <= (nxt == ST_WDATA);
         busy <= (nxt != ST_IDLE);
         done <= (nxt == ST_DONE);
         if (state == ST_DONE && rw_q == CMD_READ) rdata <= rd_word;
      end
   end

   spi_host_shreg #(
      .W  (SH_W),
      .PW (DATA_W)
   ) u_shreg (
      .sck       (sck),
      .rst       (rst),
      .load      (sh_load),
      .load_val  (sh_val),
      .shift     (sh_shift),
      .ser_in    (sdo),
      .lsb_first (LSB_FIRST),
      .ser_out   (sh_out),
      .par_out   (rd_word)
   );

endmodule

// File: tb/tb_spi_host_seq.sv
// Directed bench for spi_host_seq: per-cycle expected outputs queued at stimulus time, popped each cycle.
module tb_spi_host_seq;

   logic       sck = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic       abort = 1'b0;
   logic       sdo = 1'b0;
   logic       sdi, ss, lA, dA, busy, done;
   logic [7:0] rdata;

   int tests = 0;
   int fails = 0;
   logic [5:0] exp_q[$];

   spi_host_seq dut (
      .sck   (sck),
      .rst   (rst),
      .start (start),
      .rw    (rw),
      .addr  (addr),
      .wdata (wdata),
      .abort (abort),
      .sdo   (sdo),
      .sdi   (sdi),
      .ss    (ss),
      .lA    (lA),
      .dA    (dA),
      .busy  (busy),
      .done  (done),
      .rdata (rdata)
   );

   always #5 sck = ~sck;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic fbit(input logic [7:0] v, input int i);
`ifdef SPI_HOST_LSB_FIRST_EN
      return v[i];
`else
      return v[7-i];
`endif
   endfunction

   // Expected {sdi, ss, lA, dA, busy, done} for cycle k after the edge that accepted start.
   function automatic logic [5:0] model(input logic w, input logic [7:0] a, input logic [7:0] wd,
                                        input int k, input int abort_cyc);
      int   n;
      logic b_sdi, b_ss, b_la, b_da, b_busy, b_done;
      n = w ? 17 : 18;
      b_sdi = 0; b_ss = 0; b_la = 0; b_da = 0; b_busy = 0; b_done = 0;
      if (abort_cyc > 0 && k > abort_cyc) return '0;
      if (k <= n) begin
         b_ss = 1; b_busy = 1;
         if (k == 1) b_sdi = w;
         else if (k <= 9) begin b_la = 1; b_sdi = fbit(a, k - 2); end
         else if (w) begin b_da = 1; b_sdi = fbit(wd, k - 10); end
      end else if (k == n + 1) begin
         b_busy = 1; b_done = 1;
      end
      return {b_sdi, b_ss, b_la, b_da, b_busy, b_done};
   endfunction

   task automatic run_frame(input logic w, input logic [7:0] a, input logic [7:0] wd,
                            input logic [7:0] sd, input int abort_cyc, input int restart_cyc,
                            input int rst_cyc);
      int ncyc;
      logic [5:0] got, e;
      ncyc = (abort_cyc > 0) ? abort_cyc + 3 : (w ? 17 : 18) + 3;
      for (int k = 1; k <= ncyc; k++) exp_q.push_back(model(w, a, wd, k, abort_cyc));
      start = 1'b1; rw = w; addr = a; wdata = wd;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge sck); #1;
         got = {sdi, ss, lA, dA, busy, done};
         e = exp_q.pop_front();
         check($sformatf("frame a=%0h cycle %0d", a, k), {26'd0, got}, {26'd0, e});
         start = (k == restart_cyc);
         rw    = (k == restart_cyc) ? ~w : w;
         abort = (k == abort_cyc);
         sdo   = (!w && k >= 11 && k <= 18) ? fbit(sd, k - 11) : 1'b0;
         if (k == rst_cyc) begin
            #3 rst = 1'b1;
            #1 check("async reset mid-frame", {18'd0, sdi, ss, lA, dA, busy, done, rdata}, 32'd0);
            exp_q.delete();
            break;
         end
      end
      start = 1'b0; abort = 1'b0; sdo = 1'b0;
   endtask

   initial begin
      #1 check("outputs during reset", {18'd0, sdi, ss, lA, dA, busy, done, rdata}, 32'd0);
      repeat (2) @(posedge sck);
      #1 rst = 1'b0;
      @(posedge sck); #1 check("idle after reset", {29'd0, ss, busy, done}, 32'd0);

      run_frame(1'b1, 8'hA5, 8'h3C, 8'h00, 0, 0, 0);
      run_frame(1'b0, 8'h0F, 8'h00, 8'h96, 0, 0, 0);
      check("read rdata", {24'd0, rdata}, 32'h96);

      run_frame(1'b0, 8'h33, 8'h00, 8'h5A, 5, 0, 0);
      check("abort keeps rdata", {24'd0, rdata}, 32'h96);

      start = 1'b1; rw = 1'b1; abort = 1'b1;
      @(posedge sck); #1 start = 1'b0; abort = 1'b0;
      check("abort beats start in idle", {30'd0, ss, busy}, 32'd0);
      repeat (3) @(posedge sck);
      #1 check("dropped start stays dropped", {29'd0, ss, busy, done}, 32'd0);

      run_frame(1'b1, 8'hC3, 8'h81, 8'h00, 0, 8, 0);
      repeat (2) @(posedge sck);
      #1 check("no queued frame after busy start", {29'd0, ss, busy, done}, 32'd0);

      run_frame(1'b0, 8'h44, 8'h00, 8'hE7, 0, 0, 13);
      #2 rst = 1'b0;
      run_frame(1'b1, 8'h5A, 8'hC3, 8'h00, 0, 0, 0);
      check("rdata after reset and write", {24'd0, rdata}, 32'h00);

      run_frame(1'b0, 8'hFF, 8'h00, 8'h81, 0, 0, 0);
      check("read rdata second", {24'd0, rdata}, 32'h81);
      run_frame(1'b1, 8'h01, 8'h80, 8'h00, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
